// File: rtl/spi_slave_rx.sv
// SPI peripheral receiver: oversamples sclk/mosi, assembles MSB-first bytes,
// hands them off over valid/ack, and shifts a response byte out on miso.
module spi_slave_rx #(
  parameter int unsigned IDLE_TIMEOUT = 16,
  parameter bit          SEQ_CHECK    = 1'b1
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       sclk,
  input  logic       mosi,
  output logic       miso,
  input  logic [7:0] tx_data,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  input  logic       rx_ack,
  output logic       overrun,
  output logic       frame_error,
  output logic       seq_error
);

  localparam int unsigned BYTE_W = 8;
  localparam int unsigned CNT_W  = 3;
  localparam int unsigned IDLE_W = 8;

  localparam logic [IDLE_W-1:0] IDLE_MAX = IDLE_W'(IDLE_TIMEOUT);
  localparam logic [IDLE_W-1:0] IDLE_THR = IDLE_W'(IDLE_TIMEOUT - 1);

  // Synchronizer and edge-detect state
  logic sclk_meta_q, sclk_meta_d;
  logic sclk_s_q,    sclk_s_d;
  logic sclk_dly_q,  sclk_dly_d;
  logic mosi_meta_q, mosi_meta_d;
  logic mosi_s_q,    mosi_s_d;

  // Receive / transmit datapath
  logic [BYTE_W-2:0] shift_q,    shift_d;
  logic [CNT_W-1:0]  bit_cnt_q,  bit_cnt_d;
  logic [IDLE_W-1:0] idle_cnt_q, idle_cnt_d;
  logic [BYTE_W-1:0] tx_shift_q, tx_shift_d;

  // Consumer-facing state
  logic [BYTE_W-1:0] rx_data_q,   rx_data_d;
  logic              rx_valid_q,  rx_valid_d;
  logic              overrun_q,   overrun_d;
  logic              frame_err_q, frame_err_d;
  logic              seq_err_q,   seq_err_d;
  logic              seq_armed_q, seq_armed_d;
  logic [BYTE_W-1:0] last_byte_q, last_byte_d;

  logic              rise_c;
  logic              fall_c;
  logic              byte_done_c;
  logic              timeout_c;
  logic              accept_c;
  logic [BYTE_W-1:0] byte_c;

  assign rise_c      = sclk_s_q & ~sclk_dly_q;
  assign fall_c      = ~sclk_s_q & sclk_dly_q;
  assign byte_done_c = rise_c && (bit_cnt_q == CNT_W'(7));
  assign byte_c      = {shift_q, mosi_s_q};
  // A rise on the threshold cycle keeps the frame alive
  assign timeout_c   = !rise_c && (idle_cnt_q == IDLE_THR) && (bit_cnt_q != '0);
  assign accept_c    = byte_done_c && (!rx_valid_q || rx_ack);

  // Next-state logic for synchronizers, framing, handshake and response shifter
  always_comb begin
    sclk_meta_d = sclk;
    sclk_s_d    = sclk_meta_q;
    sclk_dly_d  = sclk_s_q;
    mosi_meta_d = mosi;
    mosi_s_d    = mosi_meta_q;

    shift_d     = shift_q;
    bit_cnt_d   = bit_cnt_q;
    idle_cnt_d  = idle_cnt_q;
    tx_shift_d  = tx_shift_q;
    rx_data_d   = rx_data_q;
    rx_valid_d  = rx_valid_q;
    overrun_d   = overrun_q;
    frame_err_d = 1'b0;
    seq_err_d   = seq_err_q;
    seq_armed_d = seq_armed_q;
    last_byte_d = last_byte_q;

    // Bit capture and idle tracking
    if (rise_c) begin
      shift_d    = {shift_q[BYTE_W-3:0], mosi_s_q};
      bit_cnt_d  = bit_cnt_q + CNT_W'(1);
      idle_cnt_d = '0;
    end else begin
      if (idle_cnt_q != IDLE_MAX) begin
        idle_cnt_d = idle_cnt_q + IDLE_W'(1);
      end
      if (timeout_c) begin
        bit_cnt_d   = '0;
        frame_err_d = 1'b1;
      end
    end

    // Handshake: a completed byte loads only if the holding register is free
    if (byte_done_c) begin
      if (accept_c) begin
        rx_data_d  = byte_c;
        rx_valid_d = 1'b1;
      end else begin
        overrun_d = 1'b1;
      end
    end else if (rx_valid_q && rx_ack) begin
      rx_valid_d = 1'b0;
    end

    // Incrementing-sequence check on accepted bytes only
    if (accept_c) begin
      if (SEQ_CHECK && seq_armed_q && (byte_c != last_byte_q + BYTE_W'(1))) begin
        seq_err_d = 1'b1;
      end
      last_byte_d = byte_c;
      seq_armed_d = 1'b1;
    end

    // Response shifter: reload while idle at a byte boundary, shift on falling sclk
    if (timeout_c) begin
      tx_shift_d = tx_data;
    end else if (fall_c && (bit_cnt_q != '0)) begin
      tx_shift_d = {tx_shift_q[BYTE_W-2:0], 1'b0};
    end else if ((bit_cnt_q == '0) && !rise_c && !fall_c) begin
      tx_shift_d = tx_data;
    end
  end

  // State register with synchronous reset
  always_ff @(posedge clock) begin
    if (reset) begin
      sclk_meta_q <= 1'b0;
      sclk_s_q    <= 1'b0;
      sclk_dly_q  <= 1'b0;
      mosi_meta_q <= 1'b0;
      mosi_s_q    <= 1'b0;
      shift_q     <= '0;
      bit_cnt_q   <= '0;
      idle_cnt_q  <= '0;
      tx_shift_q  <= '0;
      rx_data_q   <= '0;
      rx_valid_q  <= 1'b0;
      overrun_q   <= 1'b0;
      frame_err_q <= 1'b0;
      seq_err_q   <= 1'b0;
      seq_armed_q <= 1'b0;
      last_byte_q <= '0;
    end else begin
      sclk_meta_q <= sclk_meta_d;
      sclk_s_q    <= sclk_s_d;
      sclk_dly_q  <= sclk_dly_d;
      mosi_meta_q <= mosi_meta_d;
      mosi_s_q    <= mosi_s_d;
      shift_q     <= shift_d;
      bit_cnt_q   <= bit_cnt_d;
      idle_cnt_q  <= idle_cnt_d;
      tx_shift_q  <= tx_shift_d;
      rx_data_q   <= rx_data_d;
      rx_valid_q  <= rx_valid_d;
      overrun_q   <= overrun_d;
      frame_err_q <= frame_err_d;
      seq_err_q   <= seq_err_d;
      seq_armed_q <= seq_armed_d;
      last_byte_q <= last_byte_d;
    end
  end

  assign miso        = tx_shift_q[BYTE_W-1];
  assign rx_data     = rx_data_q;
  assign rx_valid    = rx_valid_q;
  assign overrun     = overrun_q;
  assign frame_error = frame_err_q;
  assign seq_error   = seq_err_q;

endmodule

// File: tb/tb_spi_slave_rx.sv
// Scoreboard bench for spi_slave_rx: a master model drives sclk/mosi at clock/8,
// expected bytes are queued at issue time and a monitor checks each rx_valid rise.
module tb_spi_slave_rx;

  logic       clock;
  logic       reset;
  logic       sclk;
  logic       mosi;
  logic       miso;
  logic [7:0] tx_data;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_ack;
  logic       overrun;
  logic       frame_error;
  logic       seq_error;

  int unsigned pass_cnt = 0;
  int unsigned total_cnt = 0;
  int unsigned fe_count = 0;
  bit          auto_ack = 1'b0;
  logic        prev_valid = 1'b0;
  logic [7:0]  exp_q[$];
  logic [7:0]  seen;
  int unsigned fe_base;

  spi_slave_rx #(.IDLE_TIMEOUT(16), .SEQ_CHECK(1'b1)) dut (
    .clock       (clock),
    .reset       (reset),
    .sclk        (sclk),
    .mosi        (mosi),
    .miso        (miso),
    .tx_data     (tx_data),
    .rx_data     (rx_data),
    .rx_valid    (rx_valid),
    .rx_ack      (rx_ack),
    .overrun     (overrun),
    .frame_error (frame_error),
    .seq_error   (seq_error)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Monitor: every new rx_valid pops one expected byte
  always @(negedge clock) begin
    if (reset) begin
      prev_valid = 1'b0;
    end else begin
      if (rx_valid && !prev_valid) begin
        if (exp_q.size() == 0) begin
          check("unexpected_rx_valid", {24'h0, rx_data}, 32'hFFFF_FFFF);
        end else begin
          check("rx_byte", {24'h0, rx_data}, {24'h0, exp_q.pop_front()});
        end
      end
      prev_valid = rx_valid;
    end
  end

  // Consumer: acks one cycle after seeing rx_valid when enabled
  always @(negedge clock) begin
    if (auto_ack) begin
      if (rx_valid && !rx_ack) rx_ack = 1'b1;
      else rx_ack = 1'b0;
    end
  end

  always @(negedge clock) begin
    if (frame_error) fe_count++;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  // Master model: n bits of b, MSB first, 4 clocks low / 4 clocks high
  task automatic send_bits(input logic [7:0] b, input int n, input bit lat_chk,
                           output logic [7:0] miso_seen);
    miso_seen = '0;
    for (int i = 0; i < n; i++) begin
      mosi = b[7-i];
      repeat (4) @(negedge clock);
      miso_seen = {miso_seen[6:0], miso};
      sclk = 1'b1;
      if (lat_chk && i == 7) begin
        repeat (2) @(negedge clock);
        check("latency_pre", {31'h0, rx_valid}, 32'h0);
        @(negedge clock);
        check("latency_post", {31'h0, rx_valid}, 32'h1);
        @(negedge clock);
      end else begin
        repeat (4) @(negedge clock);
      end
      sclk = 1'b0;
    end
    mosi = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, input bit expect_rx);
    logic [7:0] dummy;
    if (expect_rx) exp_q.push_back(b);
    send_bits(b, 8, 1'b0, dummy);
    repeat (6) @(negedge clock);
  endtask

  task automatic do_reset();
    @(negedge clock);
    reset = 1'b1;
    repeat (3) @(negedge clock);
    reset = 1'b0;
    repeat (2) @(negedge clock);
  endtask

  initial begin
    reset   = 1'b1;
    sclk    = 1'b0;
    mosi    = 1'b0;
    tx_data = 8'h3C;
    rx_ack  = 1'b0;
    repeat (3) @(negedge clock);
    check("rst_rx_valid", {31'h0, rx_valid}, 32'h0);
    check("rst_rx_data", {24'h0, rx_data}, 32'h0);
    check("rst_miso", {31'h0, miso}, 32'h0);
    reset = 1'b0;
    repeat (2) @(negedge clock);

    // Single byte with latency and miso response
    auto_ack = 1'b1;
    exp_q.push_back(8'hA5);
    send_bits(8'hA5, 8, 1'b1, seen);
    repeat (6) @(negedge clock);
    check("miso_3c", {24'h0, seen}, 32'h3C);
    check("rx_data_a5", {24'h0, rx_data}, 32'hA5);

    // Back-to-back incrementing bytes with ack
    do_reset();
    tx_data = 8'h55;
    send_byte(8'h00, 1'b1);
    send_byte(8'h01, 1'b1);
    send_byte(8'h02, 1'b1);
    check("seq_ok_012", {31'h0, seq_error}, 32'h0);
    check("ovr_none_012", {31'h0, overrun}, 32'h0);

    // Overrun: second byte dropped while first is unacknowledged
    do_reset();
    auto_ack = 1'b0;
    send_byte(8'h10, 1'b1);
    send_byte(8'h11, 1'b0);
    check("ovr_rx_data", {24'h0, rx_data}, 32'h10);
    check("ovr_valid", {31'h0, rx_valid}, 32'h1);
    check("ovr_flag", {31'h0, overrun}, 32'h1);
    rx_ack = 1'b1;
    @(negedge clock);
    rx_ack = 1'b0;
    @(negedge clock);
    check("ovr_ack_clear", {31'h0, rx_valid}, 32'h0);
    auto_ack = 1'b1;
    send_byte(8'h11, 1'b1);
    send_byte(8'h12, 1'b1);
    check("ovr_seq_ok", {31'h0, seq_error}, 32'h0);
    check("ovr_sticky", {31'h0, overrun}, 32'h1);

    // Sequence wrap 0xFF->0x00 is legal, 0x00->0x05 is not
    do_reset();
    send_byte(8'hFE, 1'b1);
    send_byte(8'hFF, 1'b1);
    send_byte(8'h00, 1'b1);
    check("seq_wrap_ok", {31'h0, seq_error}, 32'h0);
    send_byte(8'h05, 1'b1);
    check("seq_break", {31'h0, seq_error}, 32'h1);
    repeat (20) @(negedge clock);
    check("seq_sticky", {31'h0, seq_error}, 32'h1);

    // Truncated frame: 5 bits then idle -> one frame_error pulse
    do_reset();
    tx_data = 8'hC3;
    fe_base = fe_count;
    send_bits(8'hB0, 5, 1'b0, seen);
    repeat (30) @(negedge clock);
    check("frame_err_once", fe_count - fe_base, 32'd1);
    check("frame_no_valid", {31'h0, rx_valid}, 32'h0);
    exp_q.push_back(8'h81);
    send_bits(8'h81, 8, 1'b0, seen);
    repeat (6) @(negedge clock);
    check("miso_after_timeout", {24'h0, seen}, 32'hC3);

    // Reset mid-byte discards silently
    fe_base = fe_count;
    send_bits(8'hF0, 4, 1'b0, seen);
    @(negedge clock);
    reset = 1'b1;
    repeat (2) @(negedge clock);
    check("midrst_rx_data", {24'h0, rx_data}, 32'h0);
    check("midrst_flags", {28'h0, rx_valid, overrun, frame_error, seq_error}, 32'h0);
    check("midrst_miso", {31'h0, miso}, 32'h0);
    tx_data = 8'h99;
    reset = 1'b0;
    repeat (30) @(negedge clock);
    check("midrst_no_fe", fe_count - fe_base, 32'd0);
    exp_q.push_back(8'h7E);
    send_bits(8'h7E, 8, 1'b0, seen);
    repeat (6) @(negedge clock);
    check("miso_99", {24'h0, seen}, 32'h99);
    check("midrst_seq", {31'h0, seq_error}, 32'h0);

    check("queue_drained", exp_q.size(), 32'd0);
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
